super_register_param: RTL and testbench

//   Parametrised multi-function register: load, hold, single- and multi-bit shift, rotate,

---
 rtl/super_register_param.sv | 157 +++++++++++++++
 tb/tb_super_register_param.sv | 128 ++++++++++++
 2 files changed

// File: rtl/super_register_param.sv
// super_register_param: multi-function WIDTH-bit datapath register.
// Load/hold/shift/rotate/asr/clear/modulo count in one cycle; multi-bit shifts
// run serially one bit per enabled cycle under a busy flag.
// Build option: define SUPER_REG_SATURATE_EN to make count_up/count_down
// saturate at CNT_MAX / 0 instead of wrapping. Ports are the same either way.
module super_register_param #(
    parameter int WIDTH   = 8,
    parameter int CNT_MAX = (2**WIDTH) - 1,
    parameter int AMT_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_shift_right,
    input  logic             in_shift_left,
    input  logic [AMT_W-1:0] shift_amt,
    output logic [WIDTH-1:0] out_data,
    output logic             flag,
    output logic             busy,
    output logic             zero
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(CNT_MAX);

    localparam logic [3:0] OP_LOAD  = 4'd0;
    localparam logic [3:0] OP_SHR   = 4'd1;
    localparam logic [3:0] OP_SHL   = 4'd2;
    localparam logic [3:0] OP_ROTR  = 4'd3;
    localparam logic [3:0] OP_ROTL  = 4'd4;
    localparam logic [3:0] OP_STORE = 4'd5;
    localparam logic [3:0] OP_CUP   = 4'd6;
    localparam logic [3:0] OP_CDN   = 4'd7;
    localparam logic [3:0] OP_ASR   = 4'd8;
    localparam logic [3:0] OP_MSHR  = 4'd9;
    localparam logic [3:0] OP_MSHL  = 4'd10;
    localparam logic [3:0] OP_CLR   = 4'd11;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;     // 1 = left, 0 = right
    logic [WIDTH-1:0] data_q, data_d;
    logic             flag_q, flag_d;

    // Single-bit shift results using the serial inputs live this cycle
    logic [WIDTH-1:0] shr_val, shl_val;
    assign shr_val = {in_shift_right, data_q[WIDTH-1:1]};
    assign shl_val = {data_q[WIDTH-2:0], in_shift_left};

    // State register; en=0 holds everything including the FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            data_q  <= '0;
            flag_q  <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            data_q  <= data_d;
            flag_q  <= flag_d;
        end
    end

    // Next-state: op decode in IDLE, serial stepping in SHIFT
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        data_d  = data_q;
        flag_d  = 1'b0;
        case (state_q)
            IDLE: begin
                case (operation)
                    OP_LOAD: data_d = in_data;
                    OP_SHR: begin
                        data_d = shr_val;
                        flag_d = data_q[0];
                    end
                    OP_SHL: begin
                        data_d = shl_val;
                        flag_d = data_q[WIDTH-1];
                    end
                    OP_ROTR: begin
                        data_d = {data_q[0], data_q[WIDTH-1:1]};
                        flag_d = data_q[0];
                    end
                    OP_ROTL: begin
                        data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                        flag_d = data_q[WIDTH-1];
                    end
                    OP_STORE: data_d = data_q;
                    OP_CUP: begin
                        if (data_q >= TOP) begin
`ifdef SUPER_REG_SATURATE_EN
                            data_d = TOP;
`else
                            data_d = '0;
`endif
                            flag_d = 1'b1;
                        end else begin
                            data_d = data_q + WIDTH'(1);
                        end
                    end
                    OP_CDN: begin
                        if (data_q == '0) begin
`ifdef SUPER_REG_SATURATE_EN
                            data_d = '0;
`else
                            data_d = TOP;
`endif
                            flag_d = 1'b1;
                        end else begin
                            data_d = data_q - WIDTH'(1);
                        end
                    end
                    OP_ASR: begin
                        data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                        flag_d = data_q[0];
                    end
                    OP_MSHR, OP_MSHL: begin
                        // First bit goes on this edge; the rest continue in SHIFT
                        if (shift_amt != '0) begin
                            dir_d  = (operation == OP_MSHL);
                            data_d = (operation == OP_MSHL) ? shl_val : shr_val;
                            flag_d = (operation == OP_MSHL) ? data_q[WIDTH-1] : data_q[0];
                            rem_d  = shift_amt - AMT_W'(1);
                            if (shift_amt != AMT_W'(1))
                                state_d = SHIFT;
                        end
                    end
                    OP_CLR: data_d = '0;
                    default: data_d = data_q;
                endcase
            end
            SHIFT: begin
                data_d = dir_q ? shl_val : shr_val;
                flag_d = dir_q ? data_q[WIDTH-1] : data_q[0];
                rem_d  = rem_q - AMT_W'(1);
                if (rem_q == AMT_W'(1))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_data = data_q;
    assign flag     = flag_q;
    assign busy     = (state_q == SHIFT);
    assign zero     = (data_q == '0);

endmodule

// File: tb/tb_super_register_param.sv
// Bench for super_register_param (WIDTH=8 defaults). Each step drives inputs,
// pushes the expected post-edge result onto a scoreboard, and pops/compares it
// one time unit after the rising edge.
module tb_super_register_param;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [3:0] operation;
    logic [7:0] in_data;
    logic       in_shift_right, in_shift_left;
    logic [2:0] shift_amt;
    logic [7:0] out_data;
    logic       flag, busy, zero;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string      tag;
        logic [7:0] d;
        logic       f;
        logic       b;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    super_register_param dut (
        .clk(clk), .rst(rst), .en(en), .operation(operation),
        .in_data(in_data), .in_shift_right(in_shift_right),
        .in_shift_left(in_shift_left), .shift_amt(shift_amt),
        .out_data(out_data), .flag(flag), .busy(busy), .zero(zero)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle, push expectation, pop and compare after the edge
    task automatic step(input string tag, input logic r, input logic e, input logic [3:0] op,
                        input logic [7:0] d, input logic sr, input logic sl, input logic [2:0] amt,
                        input logic [7:0] xd, input logic xf, input logic xb);
        exp_t x;
        rst = r; en = e; operation = op; in_data = d;
        in_shift_right = sr; in_shift_left = sl; shift_amt = amt;
        sb.push_back('{tag, xd, xf, xb});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk({x.tag, ".out"},  32'(out_data), 32'(x.d));
        chk({x.tag, ".flag"}, 32'(flag),     32'(x.f));
        chk({x.tag, ".busy"}, 32'(busy),     32'(x.b));
        chk({x.tag, ".zero"}, 32'(zero),     32'(x.d == 8'h00));
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; operation = 4'd0; in_data = 8'h00;
        in_shift_right = 1'b0; in_shift_left = 1'b0; shift_amt = 3'd0;

        //            tag       rst en  op     data   sr sl amt  out    f  b
        step("reset",    1, 1, 4'd0, 8'hA4, 0, 0, 3'd0, 8'h00, 0, 0);
        step("load",     0, 1, 4'd0, 8'hA4, 0, 0, 3'd0, 8'hA4, 0, 0);
        step("shr",      0, 1, 4'd1, 8'h00, 0, 0, 3'd0, 8'h52, 0, 0);
        step("shl",      0, 1, 4'd2, 8'h00, 0, 1, 3'd0, 8'hA5, 0, 0);
        step("rotr",     0, 1, 4'd3, 8'h00, 0, 0, 3'd0, 8'hD2, 1, 0);
        step("rotl",     0, 1, 4'd4, 8'h00, 0, 0, 3'd0, 8'hA5, 1, 0);
        step("en0",      0, 0, 4'd0, 8'h00, 0, 0, 3'd0, 8'hA5, 1, 0);
        step("store",    0, 1, 4'd5, 8'h00, 0, 0, 3'd0, 8'hA5, 0, 0);
        step("op13",     0, 1, 4'd13, 8'h11, 1, 1, 3'd0, 8'hA5, 0, 0);
        step("clear",    0, 1, 4'd11, 8'h11, 0, 0, 3'd0, 8'h00, 0, 0);

        // counting across the terminal value
        step("ld_fe",    0, 1, 4'd0, 8'hFE, 0, 0, 3'd0, 8'hFE, 0, 0);
        step("cu1",      0, 1, 4'd6, 8'h00, 0, 0, 3'd0, 8'hFF, 0, 0);
`ifdef SUPER_REG_SATURATE_EN
        step("cu2",      0, 1, 4'd6, 8'h00, 0, 0, 3'd0, 8'hFF, 1, 0);
        step("cu3",      0, 1, 4'd6, 8'h00, 0, 0, 3'd0, 8'hFF, 1, 0);
        step("clr2",     0, 1, 4'd11, 8'h00, 0, 0, 3'd0, 8'h00, 0, 0);
        step("cd_zero",  0, 1, 4'd7, 8'h00, 0, 0, 3'd0, 8'h00, 1, 0);
`else
        step("cu2",      0, 1, 4'd6, 8'h00, 0, 0, 3'd0, 8'h00, 1, 0);
        step("cu3",      0, 1, 4'd6, 8'h00, 0, 0, 3'd0, 8'h01, 0, 0);
        step("clr2",     0, 1, 4'd11, 8'h00, 0, 0, 3'd0, 8'h00, 0, 0);
        step("cd_zero",  0, 1, 4'd7, 8'h00, 0, 0, 3'd0, 8'hFF, 1, 0);
`endif
        step("ld_10",    0, 1, 4'd0, 8'h10, 0, 0, 3'd0, 8'h10, 0, 0);
        step("cd",       0, 1, 4'd7, 8'h00, 0, 0, 3'd0, 8'h0F, 0, 0);

        // arithmetic shift right keeps the sign
        step("ld_80",    0, 1, 4'd0, 8'h80, 0, 0, 3'd0, 8'h80, 0, 0);
        step("asr1",     0, 1, 4'd8, 8'h00, 0, 0, 3'd0, 8'hC0, 0, 0);
        step("asr2",     0, 1, 4'd8, 8'h00, 0, 0, 3'd0, 8'hE0, 0, 0);
        step("shl_c0",   0, 1, 4'd2, 8'h00, 0, 0, 3'd0, 8'hC0, 1, 0);

        // multi-shr by 3; load attempts during busy are ignored
        step("ld_73",    0, 1, 4'd0, 8'h73, 0, 0, 3'd0, 8'h73, 0, 0);
        step("mshr1",    0, 1, 4'd9, 8'h00, 1, 0, 3'd3, 8'hB9, 1, 1);
        step("mshr2",    0, 1, 4'd0, 8'h00, 1, 0, 3'd0, 8'hDC, 1, 1);
        step("mshr3",    0, 1, 4'd0, 8'h00, 1, 0, 3'd0, 8'hEE, 0, 0);
        step("post_ms",  0, 1, 4'd5, 8'h00, 0, 0, 3'd0, 8'hEE, 0, 0);

        // multi-shl, including amt=1 and amt=0 corners
        step("ld_81",    0, 1, 4'd0, 8'h81, 0, 0, 3'd0, 8'h81, 0, 0);
        step("mshl1",    0, 1, 4'd10, 8'h00, 0, 0, 3'd2, 8'h02, 1, 1);
        step("mshl2",    0, 1, 4'd11, 8'h00, 0, 0, 3'd7, 8'h04, 0, 0);
        step("ld_81b",   0, 1, 4'd0, 8'h81, 0, 0, 3'd0, 8'h81, 0, 0);
        step("mshl_a1",  0, 1, 4'd10, 8'h00, 0, 1, 3'd1, 8'h03, 1, 0);
        step("msh_a0",   0, 1, 4'd9, 8'h00, 1, 1, 3'd0, 8'h03, 0, 0);

        // en=0 pauses a shift; rst aborts it
        step("ld_73b",   0, 1, 4'd0, 8'h73, 0, 0, 3'd0, 8'h73, 0, 0);
        step("m5_1",     0, 1, 4'd9, 8'h00, 0, 0, 3'd5, 8'h39, 1, 1);
        step("m5_pause", 0, 0, 4'd0, 8'h00, 1, 0, 3'd0, 8'h39, 1, 1);
        step("m5_2",     0, 1, 4'd0, 8'h00, 0, 0, 3'd0, 8'h1C, 1, 1);
        step("m5_rst",   1, 1, 4'd0, 8'h00, 0, 0, 3'd0, 8'h00, 0, 0);
        step("post_rst", 0, 1, 4'd5, 8'h00, 0, 0, 3'd0, 8'h00, 0, 0);
        step("ld_55",    0, 1, 4'd0, 8'h55, 0, 0, 3'd0, 8'h55, 0, 0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
